// File: rtl/uart_transmitter_if.sv
// Host-side bus of the UART transmitter: byte write port, FIFO status,
// overflow flag with its clear, and the serial line itself.
interface uart_transmitter_if;
  logic [7:0] din;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       ovf_clr;
  logic       tx;

  // Host side drives bytes and the overflow clear, observes status and line.
  modport master (
    output din, wr_en, ovf_clr,
    input  full, empty, busy, overflow, tx
  );

  // Transmitter side consumes bytes and reports status and the serial line.
  modport slave (
    input  din, wr_en, ovf_clr,
    output full, empty, busy, overflow, tx
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: small byte FIFO feeding an LSB-first serialiser.
// Serial timing advances on the shared 16x baud enable (clken); each bit
// occupies 16 ticks. Optional parity bit and one or two stop bits.
// Frames run back-to-back while the FIFO has data.
module uart_transmitter #(
  parameter int FIFO_AW    = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clken,
  uart_transmitter_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  // Index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               overflow_q, overflow_d;

  state_t             state_q, state_d;
  logic [3:0]         tick_q, tick_d;
  logic [2:0]         idx_q, idx_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic               tx_q, tx_d;
  logic [7:0]         shift_q, shift_d;

  logic               push;
  logic               pop;
  logic               bit_end;
  logic [7:0]         head;

  // Parity of a data byte with the configured sense applied.
  function automatic logic parity_bit(input logic [7:0] data);
    return (^data) ^ (PARITY_ODD != 0);
  endfunction

  assign head    = fifo_mem[rd_ptr_q];
  assign bit_end = (tick_q == 4'd15);

  // FIFO bookkeeping: writes are gated by the registered full flag, so a
  // same-cycle pop never lets a write into a full FIFO.
  always_comb begin
    push       = bus.wr_en && !full_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q;
    if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (bus.wr_en && full_q) begin
      overflow_d = 1'b1;
    end
  end

  // Frame sequencer: every transition happens on a clken cycle; tx is
  // computed here and registered so the line never glitches.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        tick_d = 4'd0;
        if (clken && !empty_q) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (clken) begin
          tick_d = tick_q + 4'd1;
          if (bit_end) begin
            state_d = DATA;
            idx_d   = 3'd0;
            tx_d    = shift_q[0];
          end
        end
      end
      DATA: begin
        if (clken) begin
          tick_d = tick_q + 4'd1;
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                state_d = PARITY;
                tx_d    = parity_bit(shift_q);
              end else begin
                state_d    = STOP;
                tx_d       = 1'b1;
                stop_cnt_d = 1'b0;
              end
            end else begin
              idx_d = idx_q + 3'd1;
              tx_d  = shift_q[idx_q + 3'd1];
            end
          end
        end
      end
      PARITY: begin
        if (clken) begin
          tick_d = tick_q + 4'd1;
          if (bit_end) begin
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
      end
      STOP: begin
        if (clken) begin
          tick_d = tick_q + 4'd1;
          if (bit_end) begin
            if (stop_cnt_q == LAST_STOP) begin
              // Chain straight into the next start bit when data is waiting.
              if (!empty_q) begin
                pop     = 1'b1;
                shift_d = head;
                tx_d    = 1'b0;
                state_d = START;
              end else begin
                tx_d    = 1'b1;
                state_d = IDLE;
              end
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        tick_d  = 4'd0;
      end
    endcase
  end

  // Control and status registers; reset aborts any frame and drives tx high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      tick_q     <= 4'd0;
      idx_q      <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // Data-only storage: FIFO array and the shift register need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.din;
    end
    shift_q <= shift_d;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = overflow_q;
  assign bus.tx       = tx_q;

endmodule
